// File: rtl/if_id_decode_stage_pkg.sv
// ============================================================================
// Module : if_id_decode_stage_pkg
// Brief  : RISC-Z ISA opcodes, field positions and decoded-field record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package if_id_decode_stage_pkg;

    localparam logic [3:0] OPC_ALU_LAST = 4'h7;
    localparam logic [3:0] OPC_LOAD     = 4'h8;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 0;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [7:0] imm8;
        logic       mov_op;
        logic       mov_en;
        logic       reg_we;
    } dec_fields_t;

endpackage

`default_nettype wire

// File: rtl/if_id_decode_stage_instr_field_decode.sv
// ============================================================================
// Module : if_id_decode_stage_instr_field_decode
// Brief  : Combinational field split and control decode of one instruction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_decode_stage_instr_field_decode
    import if_id_decode_stage_pkg::*;
#(
    parameter logic [3:0] OPC_MOVH = 4'hA,
    parameter logic [3:0] OPC_MOVL = 4'hB
) (
    input  logic [15:0] instr,
    output dec_fields_t fields
);

    logic [3:0] w_opcode;
    logic       w_is_mov;

    assign w_opcode = instr[OPC_LSB +: 4];
    assign w_is_mov = (w_opcode == OPC_MOVH) || (w_opcode == OPC_MOVL);

    always_comb begin
        fields        = '0;
        fields.opcode = w_opcode;
        fields.rd     = instr[RD_LSB +: 4];
        fields.rs     = instr[RS_LSB +: 4];
        fields.rt     = instr[RT_LSB +: 4];
        fields.imm8   = instr[IMM_LSB +: 8];
        fields.mov_en = w_is_mov;
        fields.mov_op = (w_opcode == OPC_MOVL);
        // Store, branch/jump and NOP are the only non-writing classes
        fields.reg_we = (w_opcode <= OPC_ALU_LAST) || (w_opcode == OPC_LOAD) || w_is_mov;
    end

endmodule

`default_nettype wire

// File: rtl/if_id_decode_stage.sv
// ============================================================================
// Module : if_id_decode_stage
// Brief  : IF->ID stage, decode at input, main + skid buffer with flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_decode_stage
    import if_id_decode_stage_pkg::*;
#(
    parameter int          PC_W     = 16,
    parameter logic [3:0]  OPC_MOVH = 4'hA,
    parameter logic [3:0]  OPC_MOVL = 4'hB
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [3:0]      opcode,
    output logic [3:0]      rd,
    output logic [3:0]      rs,
    output logic [3:0]      rt,
    output logic [7:0]      imm8,
    output logic            mov_op,
    output logic            mov_en,
    output logic            reg_we
);

    dec_fields_t     w_dec;
    logic            w_in_fire;

    dec_fields_t     r_main;
    logic [PC_W-1:0] r_main_pc;
    logic            r_main_valid;
    dec_fields_t     r_skid;
    logic [PC_W-1:0] r_skid_pc;
    logic            r_skid_valid;

    if_id_decode_stage_instr_field_decode #(
        .OPC_MOVH (OPC_MOVH),
        .OPC_MOVL (OPC_MOVL)
    ) u_decode (
        .instr  (in_instr),
        .fields (w_dec)
    );

    assign in_ready  = !r_skid_valid && !reset;
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main       <= '0;
            r_main_pc    <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_pc    <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            // Data fields are left stale; only the valid flags are cleared
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (out_ready) begin
                r_main       <= r_skid;
                r_main_pc    <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            if (!r_main_valid || out_ready) begin
                r_main       <= w_dec;
                r_main_pc    <= in_pc;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_dec;
                r_skid_pc    <= in_pc;
                r_skid_valid <= 1'b1;
            end
        end else if (r_main_valid && out_ready) begin
            r_main_valid <= 1'b0;
        end
    end

    assign out_valid = r_main_valid;
    assign out_pc    = r_main_pc;
    assign opcode    = r_main.opcode;
    assign rd        = r_main.rd;
    assign rs        = r_main.rs;
    assign rt        = r_main.rt;
    assign imm8      = r_main.imm8;
    assign mov_op    = r_main.mov_op;
    assign mov_en    = r_main.mov_en;
    assign reg_we    = r_main.reg_we;

endmodule

`default_nettype wire

// File: tb/tb_if_id_decode_stage.sv
// ============================================================================
// Module : tb_if_id_decode_stage
// Brief  : Table-driven and scoreboard bench for the IF->ID decode stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_decode_stage;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [7:0]  imm8;
        logic        mov_op;
        logic        mov_en;
        logic        reg_we;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_instr, in_pc, out_pc;
    logic [3:0]  opcode, rd, rs, rt;
    logic [7:0]  imm8;
    logic        mov_op, mov_en, reg_we;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t drv_exp;
    vec_t vecs[9];

    if_id_decode_stage #(.PC_W(16), .OPC_MOVH(4'hA), .OPC_MOVL(4'hB)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm8(imm8),
        .mov_op(mov_op), .mov_en(mov_en), .reg_we(reg_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Independent reference decode from the opcode table
    function automatic exp_t model(input logic [15:0] instr, input logic [15:0] pc);
        exp_t e;
        e.pc = pc; e.opcode = instr[15:12]; e.rd = instr[11:8];
        e.rs = instr[7:4]; e.rt = instr[3:0]; e.imm8 = instr[7:0];
        e.mov_en = 1'b0; e.mov_op = 1'b0;
        case (instr[15:12])
            4'hA:    begin e.mov_en = 1'b1; e.reg_we = 1'b1; end
            4'hB:    begin e.mov_en = 1'b1; e.mov_op = 1'b1; e.reg_we = 1'b1; end
            4'h8:    e.reg_we = 1'b1;
            4'h9, 4'hC, 4'hD, 4'hE, 4'hF: e.reg_we = 1'b0;
            default: e.reg_we = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard: pop on output transfer, push on input acceptance
    always @(negedge clk) begin
        if (!reset && !flush) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(out_pc), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_output", 64'({out_pc, opcode, rd, rs, rt, imm8, mov_op, mov_en, reg_we}), 64'(e));
                end
            end
            if (in_valid && in_ready) sb.push_back(drv_exp);
        end
    end

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
        in_valid = v; in_instr = instr; in_pc = pc;
        drv_exp  = model(instr, pc);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin step(); n++; end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        vecs[0] = '{16'hA312, 16'h0040, '{16'h0040, 4'hA, 4'h3, 4'h1, 4'h2, 8'h12, 1'b0, 1'b1, 1'b1}};
        vecs[1] = '{16'hB7FF, 16'h0042, '{16'h0042, 4'hB, 4'h7, 4'hF, 4'hF, 8'hFF, 1'b1, 1'b1, 1'b1}};
        vecs[2] = '{16'h9120, 16'h0044, '{16'h0044, 4'h9, 4'h1, 4'h2, 4'h0, 8'h20, 1'b0, 1'b0, 1'b0}};
        vecs[3] = '{16'h0345, 16'h0046, '{16'h0046, 4'h0, 4'h3, 4'h4, 4'h5, 8'h45, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{16'hF000, 16'h0048, '{16'h0048, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0}};
        vecs[5] = '{16'h8ABC, 16'h004A, '{16'h004A, 4'h8, 4'hA, 4'hB, 4'hC, 8'hBC, 1'b0, 1'b0, 1'b1}};
        vecs[6] = '{16'hC00A, 16'h004C, '{16'h004C, 4'hC, 4'h0, 4'h0, 4'hA, 8'h0A, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{16'hE5A5, 16'h004E, '{16'h004E, 4'hE, 4'h5, 4'hA, 4'h5, 8'hA5, 1'b0, 1'b0, 1'b0}};
        vecs[8] = '{16'h7123, 16'h0050, '{16'h0050, 4'h7, 4'h1, 4'h2, 4'h3, 8'h23, 1'b0, 1'b0, 1'b1}};

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000);
        repeat (3) step();
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_data", 64'({out_pc, opcode, rd, imm8, reg_we}), 64'd0);
        step(); reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Table stream, out_ready high: one output per cycle after 1-cycle latency
        for (int i = 0; i < 9; i++) begin
            step();
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc; drv_exp = vecs[i].exp;
            @(negedge clk);
            if (i > 0) check("stream_no_bubble", 64'(out_valid), 64'd1);
        end
        step(); drive(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("stream_last_valid", 64'(out_valid), 64'd1);
        drain("stream_drain");

        // Stall: second instruction lands in skid, outputs frozen on first
        step(); out_ready = 1'b0; drive(1'b1, 16'h1234, 16'h0100);
        step(); drive(1'b1, 16'h2345, 16'h0102);
        @(negedge clk);
        check("stall_in_ready_first", 64'(in_ready), 64'd1);
        step(); drive(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("skid_full_in_ready", 64'(in_ready), 64'd0);
        repeat (3) step();
        @(negedge clk);
        check("stall_frozen", 64'({out_valid, out_pc, opcode, rd, rs, rt}), 64'({1'b1, 16'h0100, 16'h1234}));
        step(); out_ready = 1'b1;
        drain("stall_drain_order");

        // Flush with skid full and in_valid high
        step(); out_ready = 1'b0; drive(1'b1, 16'h3456, 16'h0200);
        step(); drive(1'b1, 16'h4567, 16'h0202);
        step(); drive(1'b0, 16'h0000, 16'h0000);
        step(); flush = 1'b1; drive(1'b1, 16'hC00A, 16'h0204); sb.delete();
        step(); flush = 1'b0; drive(1'b0, 16'h0000, 16'h0000); out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (2) step();
        @(negedge clk);
        check("flush_no_c00a", 64'(out_valid), 64'd0);

        // Flush drops an input that saw in_ready=1
        step(); flush = 1'b1; drive(1'b1, 16'h7123, 16'h0300);
        step(); flush = 1'b0; drive(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("flush_drop_input", 64'(out_valid), 64'd0);

        // Reset while stalled with valid output
        step(); out_ready = 1'b0; drive(1'b1, 16'hA555, 16'h0400);
        step(); drive(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        step(); reset = 1'b1; sb.delete();
        @(negedge clk);
        check("mid_reset_in_ready", 64'(in_ready), 64'd0);
        step();
        @(negedge clk);
        check("mid_reset_out_valid", 64'(out_valid), 64'd0);
        step(); reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);

        // NOP decode through the scoreboard plus direct flag check
        step(); drive(1'b1, 16'hF000, 16'h0500);
        step(); drive(1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("nop_flags", 64'({out_valid, mov_en, mov_op, reg_we}), 64'({1'b1, 3'b000}));
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
